if_intr_fetch: RTL

- Instruction-fetch initiator for the single-cycle-with-interrupt MIPS core: owns the PC and drives word addresses into the combinational instruction ROM.
- Captures the returned word into a one-deep instruction register (IR) carrying valid and PC tags.
- Handles redirects (branch, jump, eret) and external interrupt entry, saving EPC and status IE.
- Sits between the instruction memory and the decode/execute logic.

---
 rtl/if_intr_fetch_if.sv | 29 ++
 rtl/if_intr_fetch.sv | 128 ++++++++++++
 2 files changed

// File: rtl/if_intr_fetch_if.sv
// Fetch-unit bus bundle: instruction ROM port, IR outputs, redirect and interrupt controls.
interface if_intr_fetch_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        eret;
    logic [3:0]  intr;
    logic        int_ack;
    logic [31:0] epc;
    logic        ie;
    logic [31:0] cause;

    modport master (
        output imem_addr, inst, inst_pc, inst_valid, int_ack, epc, ie, cause,
        input  imem_inst, stall, br_taken, br_target, jump, jump_target, eret, intr
    );

    modport slave (
        input  imem_addr, inst, inst_pc, inst_valid, int_ack, epc, ie, cause,
        output imem_inst, stall, br_taken, br_target, jump, jump_target, eret, intr
    );
endinterface

// File: rtl/if_intr_fetch.sv
// Instruction fetch with one-deep IR, branch/jump/eret redirects and interrupt entry.
// Define VECTORED_INTR_EN for prioritized per-line vectors and cause reporting.
module if_intr_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0008,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic           clock,
    input  logic           reset,
    if_intr_fetch_if.master bus
);

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_valid;
    logic [31:0] r_epc;
    logic        r_ie;
    logic [31:0] r_cause;
    logic [3:0]  r_sync [SYNC_STAGES];
    logic [3:0]  r_sync_q;
    logic [3:0]  r_pend;

    logic [3:0]  w_rise;
    logic        w_redir;
    logic [31:0] w_tgt;
    logic        w_eret;
    logic        w_take;
    logic [31:0] w_vector;
    logic [3:0]  w_clr;
    logic [31:0] w_cause_nxt;

    assign w_rise  = r_sync[SYNC_STAGES-1] & ~r_sync_q;
    // Redirect inputs come from the instruction in IR, so a bubble cannot redirect.
    assign w_redir = r_valid & (bus.br_taken | bus.jump);
    assign w_tgt   = (bus.br_taken ? bus.br_target : bus.jump_target) & ALIGN_MASK;
    assign w_eret  = r_valid & bus.eret & ~bus.stall;
    assign w_take  = ~bus.stall & ~w_eret & r_ie & (|r_pend);

`ifdef VECTORED_INTR_EN
    always_comb begin
        logic       w_found;
        logic [1:0] w_idx;
        logic [3:0] w_onehot;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (r_pend[i] && !w_found) begin
                w_found = 1'b1;
                w_idx   = 2'(i);
            end
        end
        w_onehot    = 4'b0001 << w_idx;
        w_vector    = EXC_VECTOR + {27'b0, w_idx, 3'b000};
        w_clr       = w_onehot;
        w_cause_nxt = {w_redir, 25'b0, w_onehot, 2'b00};
    end
`else
    always_comb begin
        w_vector    = EXC_VECTOR;
        w_clr       = '1;
        w_cause_nxt = '0;
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
            r_sync_q <= '0;
            r_pend   <= '0;
        end else begin
            r_sync[0] <= bus.intr;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
            r_sync_q <= r_sync[SYNC_STAGES-1];
            // A fresh edge on the line being taken stays pending.
            r_pend   <= (r_pend & ~(w_take ? w_clr : 4'b0000)) | w_rise;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc      <= RESET_VECTOR & ALIGN_MASK;
            r_inst    <= '0;
            r_inst_pc <= '0;
            r_valid   <= 1'b0;
            r_epc     <= '0;
            r_ie      <= 1'b1;
            r_cause   <= '0;
        end else if (!bus.stall) begin
            if (w_eret) begin
                r_pc    <= r_epc;
                r_ie    <= 1'b1;
                r_valid <= 1'b0;
            end else if (w_take) begin
                // Return to the redirect target if one was due, else to the unfetched pc.
                r_epc   <= w_redir ? w_tgt : r_pc;
                r_pc    <= w_vector & ALIGN_MASK;
                r_ie    <= 1'b0;
                r_valid <= 1'b0;
                r_cause <= w_cause_nxt;
            end else if (w_redir) begin
                r_pc    <= w_tgt;
                r_valid <= 1'b0;
            end else begin
                r_inst    <= bus.imem_inst;
                r_inst_pc <= r_pc;
                r_valid   <= 1'b1;
                r_pc      <= r_pc + 32'd4;
            end
        end
    end

    assign bus.imem_addr  = r_pc;
    assign bus.inst       = r_inst;
    assign bus.inst_pc    = r_inst_pc;
    assign bus.inst_valid = r_valid;
    assign bus.int_ack    = w_take;
    assign bus.epc        = r_epc;
    assign bus.ie         = r_ie;
    assign bus.cause      = r_cause;

endmodule
